fp_adder_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder: a + b, the additive counterpart of the existing combinational subtractor.
- Built around a bit-serial align/normalize FSM, trading latency for area.
- Sits between operand-issue logic and the FPU result bus.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp_adder_seq.sv | 202 ++++++++++++++++++++
 tb/tb_fp_adder_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_seq.sv
// Multi-cycle IEEE-754 single-precision adder.
// Bit-serial align/normalize FSM with valid/ready on both sides.
module fp_adder_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   exc_ovf,
  output logic                   exc_inv
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int XW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX  = '1;
  localparam logic [EW-1:0]    EMAXW = {2'b00, EMAX};
  localparam logic [EXP_W-1:0] DMAX  = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     ra, rb;
  logic             sa, sb;
  logic [EW-1:0]    ex;
  logic [EXP_W-1:0] d;
  logic [XW-1:0]    am, bm;
  logic [XW:0]      rm;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb, a_ge;

  always_comb begin
    ea   = ra[W-2:MAN_W];
    eb   = rb[W-2:MAN_W];
    fa   = ra[MAN_W-1:0];
    fb   = rb[MAN_W-1:0];
    za   = (ea == '0);
    zb   = (eb == '0);
    ia   = (ea == EMAX) && (fa == '0);
    ib   = (eb == EMAX) && (fb == '0);
    na   = (ea == EMAX) && (fa != '0);
    nb   = (eb == EMAX) && (fb != '0);
    a_ge = ({ea, fa} >= {eb, fb});
  end

  logic [MAN_W:0]   mant;
  logic             up;
  logic [MAN_W+1:0] m_r;
  logic [EW-1:0]    e_r;
  logic [MAN_W-1:0] frac;

  // Round-to-nearest-even on the G/R/S tail of the normalized sum
  always_comb begin
    mant = rm[XW-1:3];
    up   = rm[2] & (rm[1] | rm[0] | mant[0]);
    m_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
    e_r  = ex + {{(EW-1){1'b0}}, m_r[MAN_W+1]};
    frac = m_r[MAN_W+1] ? m_r[MAN_W:1] : m_r[MAN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      exc_ovf   <= 1'b0;
      exc_inv   <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ex        <= '0;
      d         <= '0;
      am        <= '0;
      bm        <= '0;
      rm        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra       <= a;
            rb       <= b;
            in_ready <= 1'b0;
            exc_ovf  <= 1'b0;
            exc_inv  <= 1'b0;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          if (na || nb || (ia && ib && (ra[W-1] != rb[W-1]))) begin
            sum       <= QNAN;
            exc_inv   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (ia || ib) begin
            sum       <= ia ? ra : rb;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (za || zb) begin
            if (za && zb)
              sum <= {ra[W-1] & rb[W-1], {(W-1){1'b0}}};
            else
              sum <= za ? rb : ra;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (a_ge) begin
              sa <= ra[W-1];
              sb <= rb[W-1];
              ex <= {2'b00, ea};
              d  <= ea - eb;
              am <= {1'b1, fa, 3'b000};
              bm <= {1'b1, fb, 3'b000};
            end else begin
              sa <= rb[W-1];
              sb <= ra[W-1];
              ex <= {2'b00, eb};
              d  <= eb - ea;
              am <= {1'b1, fb, 3'b000};
              bm <= {1'b1, fa, 3'b000};
            end
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (d > DMAX) begin
            bm    <= {{(XW-1){1'b0}}, 1'b1};
            d     <= '0;
            state <= ADD;
          end else if (d == '0) begin
            state <= ADD;
          end else begin
            bm <= {1'b0, bm[XW-1:2], bm[1] | bm[0]};
            d  <= d - 1'b1;
            if (d == EXP_W'(1))
              state <= ADD;
          end
        end
        ADD: begin
          if (sa == sb)
            rm <= {1'b0, am} + {1'b0, bm};
          else
            rm <= {1'b0, am - bm};
          state <= NORM;
        end
        NORM: begin
          if (rm[XW]) begin
            rm    <= {1'b0, rm[XW:2], rm[1] | rm[0]};
            ex    <= ex + 1'b1;
            state <= ROUND;
          end else if (rm == '0) begin
            sum       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (rm[XW-1]) begin
            state <= ROUND;
          end else if (ex <= EW'(1)) begin
            sum       <= {sa, {(W-1){1'b0}}};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rm <= {rm[XW-1:0], 1'b0};
            ex <= ex - 1'b1;
          end
        end
        ROUND: begin
          if (e_r >= EMAXW) begin
            sum     <= {sa, EMAX, {MAN_W{1'b0}}};
            exc_ovf <= 1'b1;
          end else begin
            sum <= {sa, e_r[EXP_W-1:0], frac};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed-vector bench for fp_adder_seq.
// Each task drives one scenario and checks its results inline.
module tb_fp_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        exc_ovf, exc_inv;

  int n_cmp = 0;
  int n_bad = 0;

  fp_adder_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .exc_ovf(exc_ovf), .exc_inv(exc_inv)
  );

  always #5 clk = ~clk;

  task automatic do_op(
    input  logic [31:0] xa, xb,
    output logic [31:0] rs,
    output logic        rovf, rinv,
    output int          lat,
    output logic        to
  );
    to = 1'b0; lat = 0; rs = '0; rovf = 1'b0; rinv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 200) begin
        to = 1'b1;
        break;
      end
    end
    rs = sum; rovf = exc_ovf; rinv = exc_inv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if ({sum, exc_ovf, exc_inv} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h/%b%b want 0", sum, exc_ovf, exc_inv);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [31:0] va[10], vb[10], ve[10];
    logic [31:0] rs;
    logic ov, iv, to;
    int lat;
    va[0] = 32'h40400000; vb[0] = 32'hC0000000; ve[0] = 32'h3F800000;
    va[1] = 32'h40200000; vb[1] = 32'h3FC00000; ve[1] = 32'h40800000;
    va[2] = 32'h3F800000; vb[2] = 32'hBF800000; ve[2] = 32'h00000000;
    va[3] = 32'hBF800000; vb[3] = 32'hC0000000; ve[3] = 32'hC0400000;
    va[4] = 32'h3F800000; vb[4] = 32'h33800000; ve[4] = 32'h3F800000;
    va[5] = 32'h3F800000; vb[5] = 32'h33800001; ve[5] = 32'h3F800001;
    va[6] = 32'h30800000; vb[6] = 32'h3F800000; ve[6] = 32'h3F800000;
    va[7] = 32'h3F800000; vb[7] = 32'hB0800000; ve[7] = 32'h3F800000;
    va[8] = 32'h80800001; vb[8] = 32'h00800000; ve[8] = 32'h80000000;
    va[9] = 32'h3FC00000; vb[9] = 32'h3FC00000; ve[9] = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      do_op(va[i], vb[i], rs, ov, iv, lat, to);
      n_cmp++;
      if (to || rs !== ve[i] || ov || iv) begin
        n_bad++;
        $display("FAIL add_%0d %h+%h got %h ovf%b inv%b to%b want %h",
                 i, va[i], vb[i], rs, ov, iv, to, ve[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [31:0] va[8], vb[8], ve[8];
    logic [7:0]  vf;
    logic [31:0] rs;
    logic ov, iv, to;
    int lat;
    va[0] = 32'h7F800000; vb[0] = 32'hFF800000; ve[0] = 32'h7FC00000;
    va[1] = 32'h7F7FFFFF; vb[1] = 32'h7F7FFFFF; ve[1] = 32'h7F800000;
    va[2] = 32'h7FC00001; vb[2] = 32'h3F800000; ve[2] = 32'h7FC00000;
    va[3] = 32'h3F800000; vb[3] = 32'hFF800000; ve[3] = 32'hFF800000;
    va[4] = 32'h80000000; vb[4] = 32'h80000000; ve[4] = 32'h80000000;
    va[5] = 32'h80000000; vb[5] = 32'h00000000; ve[5] = 32'h00000000;
    va[6] = 32'h00000001; vb[6] = 32'hC0A00000; ve[6] = 32'hC0A00000;
    va[7] = 32'h7F7FFFFF; vb[7] = 32'h73000000; ve[7] = 32'h7F800000;
    // flag encoding per vector: bit1 = ovf, bit0 = inv
    vf = 8'b0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] wf;
      wf = (i == 0 || i == 2) ? 2'b01 :
           (i == 1 || i == 7) ? 2'b10 : 2'b00;
      do_op(va[i], vb[i], rs, ov, iv, lat, to);
      n_cmp++;
      if (to || rs !== ve[i] || {ov, iv} !== wf) begin
        n_bad++;
        $display("FAIL special_%0d %h+%h got %h flags %b%b want %h flags %b",
                 i, va[i], vb[i], rs, ov, iv, ve[i], wf);
      end
      vf[i] = to;
    end
    do_op(32'h7F800000, 32'h3F800000, rs, ov, iv, lat, to);
    n_cmp++;
    if (to || lat !== 2) begin
      n_bad++; $display("FAIL special_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] rs;
    @(negedge clk);
    a = 32'h40400000; b = 32'hC0000000; in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_bad++; $display("FAIL bp_timeout got no out_valid want 1");
    end
    a = 32'h40200000; b = 32'h3FC00000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sum !== 32'h3F800000 || in_ready !== 1'b0 || out_valid !== 1'b1)
      begin
        n_bad++;
        $display("FAIL bp_hold_%0d got %h rdy%b vld%b want 3f800000 0 1",
                 i, sum, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got rdy%b vld%b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    rs = sum;
    n_cmp++;
    if (!out_valid || rs !== 32'h40800000) begin
      n_bad++; $display("FAIL bp_next got %h want 40800000", rs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_align;
    logic seen;
    logic [31:0] rs;
    logic ov, iv, to;
    int lat;
    @(negedge clk);
    a = 32'h40400000; b = 32'h33800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid got rdy%b vld%b sum %h want 1 0 0",
               in_ready, out_valid, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_output got %b want 0", seen);
    end
    do_op(32'h40400000, 32'h33800000, rs, ov, iv, lat, to);
    n_cmp++;
    if (to || rs !== 32'h40400000 || ov || iv) begin
      n_bad++; $display("FAIL rst_next got %h want 40400000", rs);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_specials;
    test_backpressure;
    test_reset_mid_align;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
